// File: rtl/split_combine_pkg.sv
// split_combine_pkg: shared state encoding and combine-mode constants
package split_combine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPLIT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int MODE_SUM = 0;
    localparam int MODE_REV = 1;

endpackage

// File: rtl/split_combine_seq_field_sel.sv
// field_sel: combinational pick of field idx out of a packed word
module field_sel #(
    parameter int FIELD_W    = 2,
    parameter int NUM_FIELDS = 4,
    parameter int IDX_W      = $clog2(NUM_FIELDS)
) (
    input  logic [FIELD_W*NUM_FIELDS-1:0] word,
    input  logic [IDX_W-1:0]              idx,
    output logic [FIELD_W-1:0]            fld
);

    assign fld = word[idx*FIELD_W +: FIELD_W];

endmodule

// File: rtl/split_combine_seq.sv
// split_combine_seq: splits a word into fields, then sums or reverse-concatenates them
module split_combine_seq
    import split_combine_pkg::*;
#(
    parameter  int FIELD_W    = 2,
    parameter  int NUM_FIELDS = 4,
    parameter  int MODE       = 0,
    localparam int IN_W       = FIELD_W*NUM_FIELDS,
    localparam int IDX_W      = $clog2(NUM_FIELDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in,
    output logic               fld_valid,
    input  logic               fld_ready,
    output logic [FIELD_W-1:0] fld,
    output logic [IDX_W-1:0]   fld_idx,
    output logic               fld_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IN_W:0]      number
);

    state_t             state;
    logic [IN_W-1:0]    word;
    logic [IDX_W-1:0]   idx;
    logic [IN_W:0]      acc;
    logic [IN_W:0]      acc_nxt;
    logic [IN_W:0]      ext;
    logic               at_last;

    field_sel #(
        .FIELD_W   (FIELD_W),
        .NUM_FIELDS(NUM_FIELDS),
        .IDX_W     (IDX_W)
    ) u_sel (
        .word(word),
        .idx (idx),
        .fld (fld)
    );

    assign at_last   = idx == IDX_W'(NUM_FIELDS-1);
    assign in_ready  = state == IDLE;
    assign fld_valid = state == SPLIT;
    assign fld_idx   = idx;
    assign fld_last  = fld_valid && at_last;

    always_comb begin
        ext     = (IN_W+1)'(fld);
        acc_nxt = (MODE == MODE_REV) ? ((acc << FIELD_W) | ext) : (acc + ext);
    end

    // res_valid rises one cycle after entering RESULT, when number is loaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            acc       <= '0;
            number    <= '0;
            res_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    word  <= in;
                    acc   <= '0;
                    idx   <= '0;
                    state <= SPLIT;
                end
                SPLIT: if (fld_ready) begin
                    acc <= acc_nxt;
                    if (at_last) state <= RESULT;
                    else idx <= idx + 1'b1;
                end
                RESULT: if (!res_valid) begin
                    number    <= acc;
                    res_valid <= 1'b1;
                end else if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_combine_seq.sv
// tb_split_combine_seq: directed vectors for SUM and REVERSE modes side by side
module tb_split_combine_seq;

    logic       clk = 0, rst_n = 0, clear = 0, in_valid = 0, fld_ready = 1, res_ready = 1;
    logic [7:0] in = 0;
    logic       ir0, fv0, fl0, rv0, ir1, fv1, fl1, rv1;
    logic [1:0] f0, i0, f1, i1;
    logic [8:0] n0, n1;
    int         cmp = 0, bad = 0;
    logic       seen;

    typedef struct {
        logic [7:0] w;
        logic [8:0] s;
        logic [8:0] r;
    } vec_t;
    vec_t tv[6];

    always #5 clk = ~clk;

    split_combine_seq #(.FIELD_W(2), .NUM_FIELDS(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0), .in(in),
        .fld_valid(fv0), .fld_ready(fld_ready), .fld(f0), .fld_idx(i0), .fld_last(fl0),
        .res_valid(rv0), .res_ready(res_ready), .number(n0));

    split_combine_seq #(.FIELD_W(2), .NUM_FIELDS(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir1), .in(in),
        .fld_valid(fv1), .fld_ready(fld_ready), .fld(f1), .fld_idx(i1), .fld_last(fl1),
        .res_valid(rv1), .res_ready(res_ready), .number(n1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [8:0] es, input logic [8:0] er, input bit clr);
        logic [1:0] ef;
        @(negedge clk);
        chk("in_ready", ir0, 1);
        in = w;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ef = 2'(w >> (2*k));
            chk("fld_valid", fv0, 1);
            chk("fld", f0, ef);
            chk("fld_rev", f1, ef);
            chk("fld_idx", i0, k);
            chk("fld_last", fl0, k == 3);
            chk("in_ready_busy", ir0, 0);
        end
        @(negedge clk);
        chk("res_early", rv0, 0);
        @(negedge clk);
        chk("res_valid", rv0, 1);
        chk("res_valid_rev", rv1, 1);
        chk("sum", n0, es);
        chk("rev", n1, er);
        clear = clr;
        @(negedge clk);
        clear = 0;
        chk("res_done", rv0, 0);
        chk("idle", ir0, 1);
        chk("sum_hold", n0, es);
        chk("rev_hold", n1, er);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{8'h35, 9'd5,  9'h05C};
        tv[1] = '{8'hFF, 9'd12, 9'h0FF};
        tv[2] = '{8'h00, 9'd0,  9'h000};
        tv[3] = '{8'hA5, 9'd6,  9'h05A};
        tv[4] = '{8'h1B, 9'd6,  9'h0E4};
        tv[5] = '{8'h80, 9'd2,  9'h002};

        #12;
        chk("rst_fld_valid", fv0, 0);
        chk("rst_res_valid", rv0, 0);
        chk("rst_number", n0, 0);
        chk("rst_fld", f0, 0);
        chk("rst_idx", i0, 0);
        chk("rst_in_ready", ir0, 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("post_rst_in_ready", ir0, 1);

        for (int i = 0; i < 6; i++) send(tv[i].w, tv[i].s, tv[i].r, 0);

        // downstream stalls three edges on idx 2
        @(negedge clk);
        in = 8'h35;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("stall_idx", i0, 2);
        chk("stall_fld", f0, 2'b11);
        fld_ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold_idx", i0, 2);
            chk("stall_hold_fld", f0, 2'b11);
            chk("stall_hold_valid", fv0, 1);
            chk("stall_hold_last", fl0, 0);
        end
        fld_ready = 1;
        @(negedge clk);
        chk("stall_idx3", i0, 3);
        chk("stall_last", fl0, 1);
        @(negedge clk);
        chk("stall_res_early", rv0, 0);
        @(negedge clk);
        chk("stall_res_valid", rv0, 1);
        chk("stall_sum", n0, 5);
        chk("stall_rev", n1, 9'h05C);
        @(negedge clk);

        // reset during idx 1
        @(negedge clk);
        in = 8'hFF;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_idx", i0, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_fld_valid", fv0, 0);
        chk("mid_rst_res_valid", rv0, 0);
        chk("mid_rst_number", n0, 0);
        chk("mid_rst_number_rev", n1, 0);
        chk("mid_rst_fld", f0, 0);
        chk("mid_rst_idx", i0, 0);
        chk("mid_rst_last", fl0, 0);
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= rv0 | rv1;
        end
        chk("no_res_after_rst", seen, 0);
        send(8'h1B, 9'd6, 9'h0E4, 0);

        // clear mid-split drops the word
        @(negedge clk);
        in = 8'hA5;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("clr_fld_valid", fv0, 0);
        chk("clr_in_ready", ir0, 1);
        chk("clr_number", n0, 6);
        chk("clr_number_rev", n1, 9'h0E4);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= rv0 | fv0;
        end
        chk("no_res_after_clr", seen, 0);

        // clear beats an input handshake in IDLE
        @(negedge clk);
        in = 8'hFF;
        in_valid = 1;
        clear = 1;
        @(negedge clk);
        in_valid = 0;
        clear = 0;
        chk("clr_prio_in_ready", ir0, 1);
        chk("clr_prio_fld_valid", fv0, 0);

        send(8'h80, 9'd2, 9'h002, 1);
        send(8'h35, 9'd5, 9'h05C, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/split_combine_seq.md
SPLIT_COMBINE_SEQ -- requirements
Module: split_combine_seq

Interface
REQ-001 SHALL provide parameter FIELD_W, default 2, giving the bit width of one field.
REQ-002 SHALL provide parameter NUM_FIELDS, default 4, giving the fields per word (power of two, >= 2).
REQ-003 SHALL provide parameter MODE, default 0, selecting the combine operation (0 = SUM, 1 = REVERSE concatenation).
REQ-004 SHALL define derived widths: IN_W = FIELD_W*NUM_FIELDS; IDX_W = clog2(NUM_FIELDS).
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port clear, input, 1: synchronous abort of the word in progress.
REQ-008 Port in_valid, input, 1: the in word is valid.
REQ-009 Port in_ready, output, 1: the block can accept a word.
REQ-010 Port in, input, IN_W: the word to split.
REQ-011 Port fld_valid, output, 1: a field is presented.
REQ-012 Port fld_ready, input, 1: the downstream accepts the field.
REQ-013 Port fld, output, FIELD_W: the current field value.
REQ-014 Port fld_idx, output, IDX_W: the current field index (0 = LSB field).
REQ-015 Port fld_last, output, 1: the current field is index NUM_FIELDS-1.
REQ-016 Port res_valid, output, 1: the combined result is valid.
REQ-017 Port res_ready, input, 1: the downstream accepts the result.
REQ-018 Port number, output, IN_W+1: the combined result.

Function
REQ-019 SHALL implement an FSM with states IDLE, SPLIT and RESULT.
REQ-020 IDLE: in_ready=1 and all valids are 0; on in_valid&in_ready the block SHALL capture in, clear the accumulator, set idx=0 and enter SPLIT.
REQ-021 SPLIT: fld_valid=1; fld = captured word bits [idx*FIELD_W +: FIELD_W].
REQ-022 SPLIT: on fld_ready the block SHALL update the accumulator; if idx=NUM_FIELDS-1 it SHALL enter RESULT, otherwise it SHALL increment idx.
REQ-023 MODE 0: acc <= acc + fld, zero-extended to IN_W+1 bits; the result can never overflow.
REQ-024 MODE 1: acc <= (acc << FIELD_W) | fld, so field 0 ends in the MSBs; number[IN_W] is 0.
REQ-025 While fld_valid=1 and fld_ready=0, fld, fld_idx and fld_last SHALL hold stable and the accumulator SHALL not change.
REQ-026 RESULT: res_valid=1 and number = acc; on res_ready the block SHALL return to IDLE.
REQ-027 number SHALL be registered and SHALL hold its last result until the next RESULT state.
REQ-028 With fld_ready and res_ready tied to 1, latency SHALL be NUM_FIELDS+1 cycles from acceptance of a word to res_valid.
REQ-029 in_ready SHALL be 0 in SPLIT and RESULT; back-to-back words have no overlap.
REQ-030 clear=1 in any state SHALL force IDLE next cycle and drop all valids; number is unchanged.
REQ-031 clear SHALL have priority over a simultaneous handshake in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=IDLE, idx=0, acc=0, number=0, fld=0, and all valids 0.
REQ-033 Reset asserted mid-SPLIT or mid-RESULT SHALL discard the word with no result emitted.
REQ-034 After reset release, in_ready SHALL be 1 on the first clock edge.

Structure
REQ-035 Package split_combine_pkg SHALL hold the state encoding and the MODE_SUM=0 / MODE_REV=1 constants.
REQ-036 The field selection SHALL be implemented in one sub-module, field_sel (word + idx -> field), which is combinational.

Verification
REQ-037 MODE 0, in=8'b00110101, ready inputs tied to 1: fields 01,01,11,00 appear on idx 0..3; number=9'd5 five cycles after acceptance.
REQ-038 MODE 1, same input: number=9'b001011100.
REQ-039 MODE 0, in=8'hFF: number=9'd12; in=8'h00: number=0 and fld_last is asserted only on idx 3.
REQ-040 fld_ready held low for 3 cycles on idx 2: fld=11 stays stable, and the final number is still 5.
REQ-041 rst_n pulsed low during idx 1: all outputs 0 immediately, no res_valid follows, and the next word behaves normally.
REQ-042 clear asserted on the same cycle as res_valid&res_ready: the block returns to IDLE and number keeps its prior value.
